// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
// The phase word is always ordered {A,B}.
package quad_pkg;

    typedef logic [1:0] phase_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Legal successor of each phase, indexed by the current phase.
    localparam phase_t UP_NEXT   [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    localparam phase_t DOWN_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};

endpackage

// File: rtl/quad_input_sync.sv
// One-bit synchronizer for an asynchronous phase pin, followed by an optional
// stability filter compiled in when QUAD_FILTER_EN is defined.
module quad_input_sync #(
    parameter int SYNC_STAGES = 2
`ifdef QUAD_FILTER_EN
    ,
    parameter int FILTER_CYCLES = 3
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic value,
    output logic valid
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // fill_q marks which stages already hold a real pin sample since reset.
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic raw;
    logic raw_vld;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    // NOTE: state flops use <= so every stage samples the old value of its neighbour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
        end
    end

    assign raw     = sync_q[SYNC_STAGES-1];
    assign raw_vld = fill_q[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          filt_q, filt_d;
    logic          filt_vld_q, filt_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The first valid sample seeds the filter directly so priming sees the pin level.
    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves it unassigned (no latch).
        filt_d     = filt_q;
        filt_vld_d = filt_vld_q;
        cnt_d      = '0;
        if (!filt_vld_q) begin
            if (raw_vld) begin
                filt_d     = raw;
                filt_vld_d = 1'b1;
            end
        end else if (raw != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b0;
            filt_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_vld_q <= filt_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign value = filt_q;
    assign valid = filt_vld_q;
`else
    assign value = raw;
    assign valid = raw_vld;
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: per-edge step pulses, direction and a wrapping position.
// Define QUAD_FILTER_EN to add a FILTER_CYCLES stability filter on each phase.
module quadrature_decoder #(
    parameter int WIDTH         = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear_error,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] position,
    output logic             error
);

    import quad_pkg::*;

    logic a_val, a_vld, b_val, b_vld;

    quad_input_sync #(
        .SYNC_STAGES  (SYNC_STAGES)
`ifdef QUAD_FILTER_EN
        ,
        .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_sync_a (
        .clock(clock),
        .reset(reset),
        .pin  (quad_a),
        .value(a_val),
        .valid(a_vld)
    );

    quad_input_sync #(
        .SYNC_STAGES  (SYNC_STAGES)
`ifdef QUAD_FILTER_EN
        ,
        .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_sync_b (
        .clock(clock),
        .reset(reset),
        .pin  (quad_b),
        .value(b_val),
        .valid(b_vld)
    );

    phase_t           cur_q, cur_d;
    logic             cur_vld_q, cur_vld_d;
    phase_t           prev_q, prev_d;
    logic             primed_q, primed_d;
    logic             step_q, step_d;
    logic             up_down_q, up_down_d;
    logic [WIDTH-1:0] position_q, position_d;
    logic             error_q, error_d;

    always_comb begin
        cur_d      = {a_val, b_val};
        cur_vld_d  = a_vld & b_vld;
        prev_d     = prev_q;
        primed_d   = primed_q;
        step_d     = 1'b0;
        up_down_d  = up_down_q;
        position_d = position_q;
        // Clear first so an illegal transition in the same cycle wins.
        error_d    = error_q & ~clear_error;

        if (!primed_q) begin
            if (cur_vld_q) begin
                prev_d   = cur_q;
                primed_d = 1'b1;
            end
        end else begin
            // Track the pins even while disabled so re-enabling never replays an edge.
            prev_d = cur_q;
            if ((cur_q != prev_q) && enable) begin
                if (cur_q == UP_NEXT[prev_q]) begin
                    step_d     = 1'b1;
                    up_down_d  = DIR_UP;
                    position_d = position_q + WIDTH'(1);
                end else if (cur_q == DOWN_NEXT[prev_q]) begin
                    step_d     = 1'b1;
                    up_down_d  = DIR_DOWN;
                    position_d = position_q - WIDTH'(1);
                end else begin
                    error_d = 1'b1;
                end
            end
        end
    end

    // NOTE: every register, pipeline included, is reset so priming starts from a known state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_q      <= '0;
            cur_vld_q  <= 1'b0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            step_q     <= 1'b0;
            up_down_q  <= DIR_UP;
            position_q <= '0;
            error_q    <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            cur_vld_q  <= cur_vld_d;
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            step_q     <= step_d;
            up_down_q  <= up_down_d;
            position_q <= position_d;
            error_q    <= error_d;
        end
    end

    assign step     = step_q;
    assign up_down  = up_down_q;
    assign position = position_q;
    assign error    = error_q;

endmodule
